hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; it is the producer of the forward-select codes that the EX/ID operand muxes consume.
- Keeps a shadow pipeline of destination register and Tnew for the E, M, W and WD stages, plus a mult/div busy counter.
- From these it generates the D-stage stall/flush and all forward selects.
- Sits beside the datapath: it takes decoded D-stage fields and drives control into IF/ID, ID/EX and the operand muxes.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu.
- DIV_CYC, 10, busy cycles for div/divu.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- rs_D  in  5  D-stage rs field.
- rt_D  in  5  D-stage rt field.
- tuse_rs_D  in  2  cycles until rs is needed (0=D, 1=E, 2=M, 3=unused).
- tuse_rt_D  in  2  same encoding, for rt.
- wa_D  in  5  D-stage destination register (0 = none).
- tnew_D  in  2  cycles after entering E until the result exists (0 none, 1 ALU, 2 load).
- md_D  in  1  D instruction is mult/div.
- md_div_D  in  1  qualifies md_D: 1 = div.
- md_use_D  in  1  D instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  hold PC and IF/ID, bubble ID/EX.
- ForwardRSD, ForwardRTD  out  2 each  D compare operands: 00 RF, 01 ALUout_M, 10 result_W.
- ForwardRSE, ForwardRTE  out  2 each  00 RD_E, 01 ALUout_M, 10 result_W, 11 result_WD.
- ForwardRTM  out  2  M store data: 00 pipe, 10 result_W, 11 result_WD.
- md_busy  out  1  the HI/LO unit is occupied.

Behaviour:
- Shadow registers:
  - E: rs_E, rt_E, wa_E, tnew_E, md_E, md_div_E.
  - M: rt_M, wa_M, tnew_M.
  - W: wa_W.
  - WD: wa_WD.
  - cnt: 4 bits.
  - All are cleared to 0 on reset. Reset has priority over everything, including mid-stall or a counter that is running.
- Each clock edge:
  - If stall=1, E loads a bubble (all fields 0); otherwise E loads the D fields.
  - M<=E, with tnew_M = tnew_E-1, saturating at 0.
  - W<=M.
  - WD<=W.
  - D fields are never stored while stall=1.
- Stall for rs (rt is the same with rt_D/tuse_rt_D):
  - stall_rs = rs_D!=0 AND tuse_rs_D!=3 AND ((rs_D==wa_E AND tnew_E>tuse_rs_D) OR (rs_D==wa_M AND tnew_M>tuse_rs_D)).
- Mult/div stall:
  - stall_md = md_use_D AND md_busy.
  - md_busy = md_E OR cnt!=0.
- stall = stall_rs OR stall_rt OR stall_md. It is purely combinational from the shadow state and D inputs, with zero latency.
- Mult/div counter:
  - If md_E=1 at an edge, cnt loads DIV_CYC when md_div_E=1, otherwise MULT_CYC.
  - Otherwise cnt decrements when nonzero and saturates at 0.
  - Busy is therefore asserted for 1+N cycles after the op enters E.
- E forwarding (rs shown; rt is identical):
  - Priority M > W > WD > RF, matching on a nonzero address only.
  - 01 if rs_E==wa_M AND tnew_M==0.
  - Else 10 if rs_E==wa_W.
  - Else 11 if rs_E==wa_WD.
  - Else 00.
- D forwarding:
  - 01 if rs_D==wa_M AND tnew_M==0.
  - Else 10 if rs_D==wa_W.
  - Else 00. The register file write-through covers WD.
- M forwarding: ForwardRTM is 10 if rt_M==wa_W, else 11 if rt_M==wa_WD, else 00.
- Register $0 is never forwarded or stalled on.
- A stale select is harmless while stall=1.
- Widths: Tnew and Tuse comparisons are unsigned 2-bit; cnt is 4 bits (DIV_CYC ≤ 15).

Decomposition:
- Shared package:
  - FWD_RF=2'b00, FWD_M=2'b01, FWD_W=2'b10, FWD_WD=2'b11.
  - TUSE_NONE=2'd3.
  - Tnew constants TNEW_NONE/ALU/LOAD.
  - MULT_CYC/DIV_CYC defaults.
- One natural sub-module, fwd_sel: a combinational priority match of one source address against M/W/WD, instantiated five times.
- The shadow pipeline and counter stay in hazard_ctrl.

Test Plan:
1. After reset with all-zero inputs -> stall=0, all Forward*=00, md_busy=0. Assert reset mid-div (cnt=7) -> next cycle cnt=0, md_busy=0.
2. addu $3 (tnew 1) then beq on $3 (tuse_rs 0) -> stall=1 for exactly 1 cycle. Next cycle beq sees ForwardRSD=01.
3. lw $5 (tnew 2) then addu using $5 (tuse 1) -> stall 1 cycle. When addu is in E, ForwardRSE=10 (result_W).
4. addu $4 then three independent ops then sub $4 source -> as the producer moves through the stages, ForwardRTE for consumers at distance 1/2/3 = 01/10/11. At distance 4 -> 00.
5. Instruction writing $0 (tnew 1) followed by a beq on $0 -> stall=0, Forward*=00.
6. div followed immediately by mfhi -> stall held for 11 cycles, released when cnt reaches 0. With mult instead -> 6 cycles.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forward selects, Tuse/Tnew codes, mult/div latencies.
// Also holds the per-operand RAW stall predicate used by both source fields.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_M   = 2'b01;
   localparam logic [1:0] FWD_W   = 2'b10;
   localparam logic [1:0] FWD_WD  = 2'b11;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_NONE = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wa;
      logic [1:0] tnew;
      logic       md;
      logic       md_div;
   } e_stage_t;

   // Operand is needed before an in-flight producer in E or M can supply it.
   function automatic logic raw_stall(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] wa_e, input logic [1:0] tnew_e,
                                      input logic [4:0] wa_m, input logic [1:0] tnew_m);
      return (src != 5'd0) && (tuse != TUSE_NONE) &&
             (((src == wa_e) && (tnew_e > tuse)) || ((src == wa_m) && (tnew_m > tuse)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority match of one source register against the M, W and WD destinations; purely combinational.
// Stages can be masked per instance so D and M consumers only see the sources they can use.
module hazard_ctrl_fwd_sel
   import hazard_ctrl_pkg::*;
#(
   parameter bit USE_M  = 1'b1,
   parameter bit USE_WD = 1'b1
) (
   input  logic [4:0] src,
   input  logic [4:0] wa_M,
   input  logic [1:0] tnew_M,
   input  logic [4:0] wa_W,
   input  logic [4:0] wa_WD,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (src != 5'd0) begin
         if (USE_M && (src == wa_M) && (tnew_M == TNEW_NONE))
            sel = FWD_M;
         else if (src == wa_W)
            sel = FWD_W;
         else if (USE_WD && (src == wa_WD))
            sel = FWD_WD;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow E/M/W/WD pipeline plus HI/LO busy counter driving stall and forward selects.
// stall and all selects are combinational (zero latency) from shadow state and the D-stage fields.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] tuse_rs_D,
   input  logic [1:0] tuse_rt_D,
   input  logic [4:0] wa_D,
   input  logic [1:0] tnew_D,
   input  logic       md_D,
   input  logic       md_div_D,
   input  logic       md_use_D,
   output logic       stall,
   output logic [1:0] ForwardRSD,
   output logic [1:0] ForwardRTD,
   output logic [1:0] ForwardRSE,
   output logic [1:0] ForwardRTE,
   output logic [1:0] ForwardRTM,
   output logic       md_busy
);

   e_stage_t   e_q;
   logic [4:0] rt_M, wa_M, wa_W, wa_WD;
   logic [1:0] tnew_M;
   logic [3:0] cnt;

   logic stall_rs, stall_rt, stall_md;

   assign md_busy  = e_q.md || (cnt != 4'd0);
   assign stall_rs = raw_stall(rs_D, tuse_rs_D, e_q.wa, e_q.tnew, wa_M, tnew_M);
   assign stall_rt = raw_stall(rt_D, tuse_rt_D, e_q.wa, e_q.tnew, wa_M, tnew_M);
   assign stall_md = md_use_D && md_busy;
   assign stall    = stall_rs || stall_rt || stall_md;

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q    <= '0;
         rt_M   <= 5'd0;
         wa_M   <= 5'd0;
         tnew_M <= 2'd0;
         wa_W   <= 5'd0;
         wa_WD  <= 5'd0;
         cnt    <= 4'd0;
      end else begin
         if (stall)
            e_q <= '0;
         else
            e_q <= '{rs: rs_D, rt: rt_D, wa: wa_D, tnew: tnew_D, md: md_D, md_div: md_div_D};
         rt_M   <= e_q.rt;
         wa_M   <= e_q.wa;
         tnew_M <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
         wa_W   <= wa_M;
         wa_WD  <= wa_W;
         // The op sits in E for one cycle, then the counter covers the remaining latency.
         if (e_q.md)
            cnt <= e_q.md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
         else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   hazard_ctrl_fwd_sel #(.USE_M(1'b1), .USE_WD(1'b0)) u_fwd_rsd (
      .src(rs_D), .wa_M(wa_M), .tnew_M(tnew_M), .wa_W(wa_W), .wa_WD(wa_WD), .sel(ForwardRSD));
   hazard_ctrl_fwd_sel #(.USE_M(1'b1), .USE_WD(1'b0)) u_fwd_rtd (
      .src(rt_D), .wa_M(wa_M), .tnew_M(tnew_M), .wa_W(wa_W), .wa_WD(wa_WD), .sel(ForwardRTD));
   hazard_ctrl_fwd_sel #(.USE_M(1'b1), .USE_WD(1'b1)) u_fwd_rse (
      .src(e_q.rs), .wa_M(wa_M), .tnew_M(tnew_M), .wa_W(wa_W), .wa_WD(wa_WD), .sel(ForwardRSE));
   hazard_ctrl_fwd_sel #(.USE_M(1'b1), .USE_WD(1'b1)) u_fwd_rte (
      .src(e_q.rt), .wa_M(wa_M), .tnew_M(tnew_M), .wa_W(wa_W), .wa_WD(wa_WD), .sel(ForwardRTE));
   hazard_ctrl_fwd_sel #(.USE_M(1'b0), .USE_WD(1'b1)) u_fwd_rtm (
      .src(rt_M), .wa_M(wa_M), .tnew_M(tnew_M), .wa_W(wa_W), .wa_WD(wa_WD), .sel(ForwardRTM));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each task drives a short instruction sequence and checks inline.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, wa_D;
   logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
   logic       md_D, md_div_D, md_use_D;
   logic       stall, md_busy;
   logic [1:0] ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM;

   int checks = 0;
   int errors = 0;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .wa_D(wa_D), .tnew_D(tnew_D), .md_D(md_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
      .stall(stall),
      .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD),
      .ForwardRSE(ForwardRSE), .ForwardRTE(ForwardRTE), .ForwardRTM(ForwardRTM),
      .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt,
                        input logic [4:0] wa, input logic [1:0] tnew,
                        input logic md, input logic dv, input logic use_md);
      rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
      wa_D = wa; tnew_D = tnew; md_D = md; md_div_D = dv; md_use_D = use_md;
      #1;
   endtask

   task automatic nop();
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic flush();
      nop();
      for (int i = 0; i < 16; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      nop();
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({stall, md_busy} !== 2'b00) begin
         errors++; $display("FAIL reset_ctl: stall,md_busy=%b expected 00", {stall, md_busy});
      end
      checks++;
      if ({ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM} !== 10'd0) begin
         errors++;
         $display("FAIL reset_fwd: %b expected 0", {ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM});
      end
      // Reset while a divide is counting (cnt = 7).
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      tick();            // div in E
      nop();
      tick();            // cnt = 10
      tick(); tick(); tick();  // cnt = 7
      checks++;
      if (md_busy !== 1'b1) begin
         errors++; $display("FAIL reset_div_busy: md_busy=%b expected 1", md_busy);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({md_busy, stall} !== 2'b00) begin
         errors++; $display("FAIL reset_mid_div: md_busy,stall=%b expected 00", {md_busy, stall});
      end
      flush();
   endtask

   task automatic test_alu_branch();
      drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);   // addu $3
      tick();
      drive(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // beq $3,$0
      checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL alu_branch_stall: stall=%b expected 1", stall);
      end
      tick();
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL alu_branch_release: stall=%b expected 0", stall);
      end
      checks++;
      if (ForwardRSD !== 2'b01) begin
         errors++; $display("FAIL alu_branch_fwd: ForwardRSD=%b expected 01", ForwardRSD);
      end
      flush();
   endtask

   task automatic test_load_use();
      drive(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);   // lw $5
      tick();
      drive(5'd5, 5'd6, 2'd1, 2'd1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);   // addu $7,$5,$6
      checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL load_use_stall: stall=%b expected 1", stall);
      end
      tick();
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL load_use_release: stall=%b expected 0", stall);
      end
      tick();
      nop();
      checks++;
      if (ForwardRSE !== 2'b10) begin
         errors++; $display("FAIL load_use_fwdE: ForwardRSE=%b expected 10", ForwardRSE);
      end
      flush();
   endtask

   task automatic test_distance();
      logic [1:0] exp_sel;
      for (int d = 1; d <= 4; d++) begin
         drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);   // addu $4
         tick();
         for (int k = 1; k < d; k++) begin
            drive(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
            tick();
         end
         drive(5'd11, 5'd4, 2'd1, 2'd1, 5'd12, 2'd1, 1'b0, 1'b0, 1'b0); // sub $12,$11,$4
         checks++;
         if (stall !== 1'b0) begin
            errors++; $display("FAIL dist%0d_stall: stall=%b expected 0", d, stall);
         end
         tick();
         nop();
         case (d)
            1:       exp_sel = 2'b01;
            2:       exp_sel = 2'b10;
            3:       exp_sel = 2'b11;
            default: exp_sel = 2'b00;
         endcase
         checks++;
         if (ForwardRTE !== exp_sel) begin
            errors++; $display("FAIL dist%0d_fwdE: ForwardRTE=%b expected %b", d, ForwardRTE, exp_sel);
         end
         flush();
      end
   endtask

   task automatic test_store_data();
      drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);   // addu $6
      tick();
      drive(5'd7, 5'd6, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // sw $6
      tick();
      nop();
      checks++;
      if (ForwardRTE !== 2'b01) begin
         errors++; $display("FAIL store_fwdE: ForwardRTE=%b expected 01", ForwardRTE);
      end
      tick();
      checks++;
      if (ForwardRTM !== 2'b10) begin
         errors++; $display("FAIL store_fwdM: ForwardRTM=%b expected 10", ForwardRTM);
      end
      flush();
   endtask

   task automatic test_zero_reg();
      drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);   // writes $0
      tick();
      drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // beq $0,$0
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL zero_stall: stall=%b expected 0", stall);
      end
      tick();
      checks++;
      if ({ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE} !== 8'd0) begin
         errors++;
         $display("FAIL zero_fwd: %b expected 0", {ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE});
      end
      flush();
   endtask

   task automatic test_muldiv(input logic is_div, input int exp_cycles);
      int n;
      drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, is_div, 1'b1);   // div/mult
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL md%0d_issue: stall=%b expected 0", is_div, stall);
      end
      tick();
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1);     // mfhi $3
      n = 0;
      while (stall === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== exp_cycles) begin
         errors++; $display("FAIL md%0d_stall_len: stalled %0d cycles expected %0d", is_div, n, exp_cycles);
      end
      checks++;
      if (md_busy !== 1'b0) begin
         errors++; $display("FAIL md%0d_busy_end: md_busy=%b expected 0", is_div, md_busy);
      end
      flush();
   endtask

   initial begin
      test_reset();
      test_alu_branch();
      test_load_use();
      test_distance();
      test_store_data();
      test_zero_reg();
      test_muldiv(1'b1, 11);
      test_muldiv(1'b0, 6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
